// File: rtl/core_pkg.sv
// Core-wide widths, control encodings and the EXE->MEM payload shared by the pipeline stages.
package core_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned CSR_ADDR_WIDTH = 12;

    typedef enum logic [3:0] {
        MEM_IDLE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_ctrl_e;

    typedef enum logic [1:0] {
        GPR_NONE  = 2'd0,
        GPR_ALU   = 2'd1,
        GPR_MEM   = 2'd2,
        GPR_PRGMC = 2'd3
    } gpr_ctrl_e;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_ctrl_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     exe_out;
        logic [DATA_WIDTH-1:0]     op3;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
        mem_ctrl_e                 mem_ctrl;
        gpr_ctrl_e                 gpr_ctrl;
        csr_ctrl_e                 csr_ctrl;
    } exe2mem_t;

    function automatic logic MEM_IS_LOAD(input mem_ctrl_e ctrl);
        return ctrl inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic MEM_IS_STORE(input mem_ctrl_e ctrl);
        return ctrl inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

endpackage

// File: rtl/mem2wb_pkg.sv
// MEM->WB payload: load result plus the EXE fields WB still needs.
package mem2wb_pkg;

    import core_pkg::*;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     exe_out;
        logic [DATA_WIDTH-1:0]     mem_rdata;
        logic [DATA_WIDTH-1:0]     op3;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
        gpr_ctrl_e                 gpr_ctrl;
        csr_ctrl_e                 csr_ctrl;
    } mem2wb_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: shifts the addressed bytes down and sign/zero-extends by access type.
module mem_load_align
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            addr_lo,
    input  mem_ctrl_e             mem_ctrl,
    output logic [DATA_WIDTH-1:0] ext_data_c
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        ext_data_c = '0;
        case (mem_ctrl)
            MEM_LB:  ext_data_c = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            MEM_LBU: ext_data_c = DATA_WIDTH'(shifted[7:0]);
            MEM_LH:  ext_data_c = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            MEM_LHU: ext_data_c = DATA_WIDTH'(shifted[15:0]);
            MEM_LW:  ext_data_c = shifted;
            default: ext_data_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: runs the data-bus transaction for loads/stores and registers the WB payload.
// Non-memory and misaligned ops bypass the bus and reach WB one cycle after acceptance.
module mem_stage
    import core_pkg::*;
    import mem2wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = core_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = core_pkg::ADDR_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    exe2mem_valid_i,
    output logic                    exe2mem_ready_o,
    input  exe2mem_t                exe2mem_i,
    output logic                    d_req_o,
    input  logic                    d_gnt_i,
    output logic                    d_we_o,
    output logic [ADDR_WIDTH-1:0]   d_addr_o,
    output logic [DATA_WIDTH/8-1:0] d_be_o,
    output logic [DATA_WIDTH-1:0]   d_wdata_o,
    input  logic                    d_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   d_rdata_i,
    output logic                    mem2wb_valid_o,
    input  logic                    mem2wb_ready_i,
    output mem2wb_t                 mem2wb_o,
    output logic                    misaligned_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        FULL = 2'd3
    } state_e;

    state_e                state_q, state_n;
    exe2mem_t              req_q, req_n;
    logic                  d_req_n, d_we_n;
    logic [ADDR_WIDTH-1:0] d_addr_n;
    logic [BE_WIDTH-1:0]   d_be_n;
    logic [DATA_WIDTH-1:0] d_wdata_n;
    logic                  mem2wb_valid_n;
    mem2wb_t               mem2wb_n;
    logic                  misaligned_n;
    logic                  accept_c;
    logic [DATA_WIDTH-1:0] load_data_c;

    function automatic logic is_misaligned(input mem_ctrl_e ctrl, input logic [1:0] a);
        case (ctrl)
            MEM_LH, MEM_LHU, MEM_SH: return a[0];
            MEM_LW, MEM_SW:          return a != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [BE_WIDTH-1:0] byte_en(input mem_ctrl_e ctrl, input logic [1:0] a);
        case (ctrl)
            MEM_LB, MEM_LBU, MEM_SB: return BE_WIDTH'(1) << a;
            MEM_LH, MEM_LHU, MEM_SH: return BE_WIDTH'(3) << {a[1], 1'b0};
            MEM_LW, MEM_SW:          return '1;
            default:                 return '0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_data(input mem_ctrl_e ctrl,
                                                         input logic [DATA_WIDTH-1:0] d);
        case (ctrl)
            MEM_SB:  return {BE_WIDTH{d[7:0]}};
            MEM_SH:  return {(DATA_WIDTH/16){d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic mem2wb_t to_wb(input exe2mem_t p, input logic [DATA_WIDTH-1:0] rdata);
        mem2wb_t w;
        w.exe_out   = p.exe_out;
        w.mem_rdata = rdata;
        w.op3       = p.op3;
        w.rd        = p.rd;
        w.csr_waddr = p.csr_waddr;
        w.gpr_ctrl  = p.gpr_ctrl;
        w.csr_ctrl  = p.csr_ctrl;
        return w;
    endfunction

    mem_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata      (d_rdata_i),
        .addr_lo    (req_q.exe_out[1:0]),
        .mem_ctrl   (req_q.mem_ctrl),
        .ext_data_c (load_data_c)
    );

    // Ready is combinational in FULL so a consumed payload can be replaced in the same cycle.
    assign exe2mem_ready_o = (state_q == IDLE) || ((state_q == FULL) && mem2wb_ready_i);
    assign accept_c        = exe2mem_valid_i && exe2mem_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            req_q          <= '0;
            d_req_o        <= 1'b0;
            d_we_o         <= 1'b0;
            d_addr_o       <= '0;
            d_be_o         <= '0;
            d_wdata_o      <= '0;
            mem2wb_valid_o <= 1'b0;
            mem2wb_o       <= '0;
            misaligned_o   <= 1'b0;
        end else begin
            state_q        <= state_n;
            req_q          <= req_n;
            d_req_o        <= d_req_n;
            d_we_o         <= d_we_n;
            d_addr_o       <= d_addr_n;
            d_be_o         <= d_be_n;
            d_wdata_o      <= d_wdata_n;
            mem2wb_valid_o <= mem2wb_valid_n;
            mem2wb_o       <= mem2wb_n;
            misaligned_o   <= misaligned_n;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_n        = state_q;
        req_n          = req_q;
        d_req_n        = d_req_o;
        d_we_n         = d_we_o;
        d_addr_n       = d_addr_o;
        d_be_n         = d_be_o;
        d_wdata_n      = d_wdata_o;
        mem2wb_valid_n = mem2wb_valid_o;
        mem2wb_n       = mem2wb_o;
        misaligned_n   = 1'b0;

        case (state_q)
            IDLE: ;
            REQ: begin
                if (d_gnt_i) begin
                    d_req_n = 1'b0;
                    state_n = RESP;
                    if (d_rvalid_i) begin
                        mem2wb_n = to_wb(req_q, MEM_IS_LOAD(req_q.mem_ctrl) ? load_data_c : '0);
                        mem2wb_valid_n = 1'b1;
                        state_n        = FULL;
                    end
                end
            end
            RESP: begin
                if (d_rvalid_i) begin
                    mem2wb_n = to_wb(req_q, MEM_IS_LOAD(req_q.mem_ctrl) ? load_data_c : '0);
                    mem2wb_valid_n = 1'b1;
                    state_n        = FULL;
                end
            end
            FULL: begin
                if (mem2wb_ready_i) begin
                    mem2wb_valid_n = 1'b0;
                    state_n        = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // New payload: accepted only from IDLE or from FULL while WB drains.
        if (accept_c) begin
            if (exe2mem_i.mem_ctrl == MEM_IDLE) begin
                mem2wb_n       = to_wb(exe2mem_i, '0);
                mem2wb_valid_n = 1'b1;
                state_n        = FULL;
            end else if (is_misaligned(exe2mem_i.mem_ctrl, exe2mem_i.exe_out[1:0])) begin
                mem2wb_n          = to_wb(exe2mem_i, '0);
                mem2wb_n.gpr_ctrl = GPR_NONE;
                mem2wb_n.csr_ctrl = CSR_NONE;
                mem2wb_valid_n    = 1'b1;
                misaligned_n      = 1'b1;
                state_n           = FULL;
            end else begin
                req_n          = exe2mem_i;
                d_req_n        = 1'b1;
                d_we_n         = MEM_IS_STORE(exe2mem_i.mem_ctrl);
                d_addr_n       = ADDR_WIDTH'({exe2mem_i.exe_out[DATA_WIDTH-1:2], 2'b00});
                d_be_n         = byte_en(exe2mem_i.mem_ctrl, exe2mem_i.exe_out[1:0]);
                d_wdata_n      = store_data(exe2mem_i.mem_ctrl, exe2mem_i.op3);
                mem2wb_valid_n = 1'b0;
                state_n        = REQ;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: passthrough, aligned loads/stores, stalls, misalignment, reset.
module tb_mem_stage;

    import core_pkg::*;
    import mem2wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid;
    logic        exe_ready;
    exe2mem_t    exe_pl;
    logic        d_req;
    logic        d_gnt;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        wb_valid;
    logic        wb_ready;
    mem2wb_t     wb;
    logic        misaligned;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .exe2mem_valid_i (exe_valid),
        .exe2mem_ready_o (exe_ready),
        .exe2mem_i       (exe_pl),
        .d_req_o         (d_req),
        .d_gnt_i         (d_gnt),
        .d_we_o          (d_we),
        .d_addr_o        (d_addr),
        .d_be_o          (d_be),
        .d_wdata_o       (d_wdata),
        .d_rvalid_i      (d_rvalid),
        .d_rdata_i       (d_rdata),
        .mem2wb_valid_o  (wb_valid),
        .mem2wb_ready_i  (wb_ready),
        .mem2wb_o        (wb),
        .misaligned_o    (misaligned)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exe2mem_t mk(input mem_ctrl_e c, input logic [31:0] a,
                                    input logic [31:0] d, input gpr_ctrl_e g,
                                    input csr_ctrl_e s);
        exe2mem_t p;
        p.exe_out   = a;
        p.op3       = d;
        p.rd        = 5'd9;
        p.csr_waddr = 12'h341;
        p.mem_ctrl  = c;
        p.gpr_ctrl  = g;
        p.csr_ctrl  = s;
        return p;
    endfunction

    // Load with one wait cycle between grant and response; WB is ready throughout.
    task automatic do_load(input string tag, input mem_ctrl_e c, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        exe_valid = 1'b1;
        exe_pl    = mk(c, a, 32'h0, GPR_MEM, CSR_NONE);
        tick;
        exe_valid = 1'b0;
        check({tag, " req"},   32'(d_req), 32'd1);
        check({tag, " addr"},  d_addr, exp_addr);
        check({tag, " be"},    32'(d_be), 32'(exp_be));
        check({tag, " we"},    32'(d_we), 32'd0);
        check({tag, " ready"}, 32'(exe_ready), 32'd0);
        d_gnt = 1'b1;
        tick;
        d_gnt = 1'b0;
        check({tag, " req drop"}, 32'(d_req), 32'd0);
        d_rvalid = 1'b1;
        d_rdata  = rdata;
        tick;
        d_rvalid = 1'b0;
        check({tag, " wb valid"}, 32'(wb_valid), 32'd1);
        check({tag, " rdata"},    wb.mem_rdata, exp_data);
        check({tag, " exe_out"},  wb.exe_out, a);
        check({tag, " rd"},       32'(wb.rd), 32'd9);
        tick;
        check({tag, " drained"},  32'(wb_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        exe_valid = 1'b0;
        exe_pl    = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = 32'h0;
        wb_ready  = 1'b0;
        tick;
        tick;
        check("rst ready",    32'(exe_ready), 32'd1);
        check("rst req",      32'(d_req), 32'd0);
        check("rst we",       32'(d_we), 32'd0);
        check("rst addr",     d_addr, 32'h0);
        check("rst be",       32'(d_be), 32'h0);
        check("rst wdata",    d_wdata, 32'h0);
        check("rst wb valid", 32'(wb_valid), 32'd0);
        check("rst wb exe",   wb.exe_out, 32'h0);
        check("rst misalign", 32'(misaligned), 32'd0);
        rst = 1'b0;

        // 1: back-to-back ALU passthrough at one op per cycle
        wb_ready  = 1'b1;
        exe_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exe_pl = mk(MEM_IDLE, 32'(i), 32'h0, GPR_ALU, CSR_NONE);
            tick;
            check("alu exe_out", wb.exe_out, 32'(i));
            check("alu valid",   32'(wb_valid), 32'd1);
            check("alu no req",  32'(d_req), 32'd0);
        end
        exe_valid = 1'b0;
        tick;
        check("alu drained", 32'(wb_valid), 32'd0);

        // 2: byte/half loads with sign and zero extension
        do_load("lb",  MEM_LB,  32'h0000_1003, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
        do_load("lbu", MEM_LBU, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'h0000_0080);
        do_load("lh",  MEM_LH,  32'h0000_1002, 32'h80FF_1234, 32'h0000_1000, 4'b1100, 32'hFFFF_80FF);
        do_load("lhu", MEM_LHU, 32'h0000_1002, 32'h80FF_1234, 32'h0000_1000, 4'b1100, 32'h0000_80FF);

        // 3: halfword store, grant held off three cycles
        exe_valid = 1'b1;
        exe_pl    = mk(MEM_SH, 32'h0000_2002, 32'hABCD_5678, GPR_NONE, CSR_NONE);
        tick;
        exe_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("sh req",   32'(d_req), 32'd1);
            check("sh we",    32'(d_we), 32'd1);
            check("sh addr",  d_addr, 32'h0000_2000);
            check("sh be",    32'(d_be), 32'b1100);
            check("sh wdata", d_wdata, 32'h5678_5678);
            check("sh ready", 32'(exe_ready), 32'd0);
        end
        d_gnt = 1'b1;
        tick;
        d_gnt    = 1'b0;
        d_rvalid = 1'b1;
        d_rdata  = 32'hFFFF_FFFF;
        tick;
        d_rvalid = 1'b0;
        check("sh wb valid", 32'(wb_valid), 32'd1);
        check("sh wb rdata", wb.mem_rdata, 32'h0);
        check("sh wb op3",   wb.op3, 32'hABCD_5678);
        tick;
        check("sh drained",  32'(wb_valid), 32'd0);

        // 4: word load with grant+rvalid together, then WB back-pressure
        exe_valid = 1'b1;
        exe_pl    = mk(MEM_LW, 32'h0000_3000, 32'h0, GPR_MEM, CSR_NONE);
        tick;
        wb_ready = 1'b0;
        exe_pl   = mk(MEM_IDLE, 32'h0000_0055, 32'h0, GPR_ALU, CSR_NONE);
        d_gnt    = 1'b1;
        d_rvalid = 1'b1;
        d_rdata  = 32'hDEAD_BEEF;
        tick;
        d_gnt    = 1'b0;
        d_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("lw held valid", 32'(wb_valid), 32'd1);
            check("lw held rdata", wb.mem_rdata, 32'hDEAD_BEEF);
            check("lw exe stall",  32'(exe_ready), 32'd0);
            tick;
        end
        wb_ready = 1'b1;
        #1;
        check("lw ready on wb", 32'(exe_ready), 32'd1);
        tick;
        exe_valid = 1'b0;
        check("lw next op", wb.exe_out, 32'h0000_0055);
        check("lw next valid", 32'(wb_valid), 32'd1);
        tick;
        check("lw drained", 32'(wb_valid), 32'd0);

        // 5: misaligned word load is dropped and forwarded with writes disabled
        exe_valid = 1'b1;
        exe_pl    = mk(MEM_LW, 32'h0000_3001, 32'h0, GPR_MEM, CSR_WRITE);
        tick;
        exe_valid = 1'b0;
        check("mis pulse",   32'(misaligned), 32'd1);
        check("mis no req",  32'(d_req), 32'd0);
        check("mis valid",   32'(wb_valid), 32'd1);
        check("mis gpr",     32'(wb.gpr_ctrl), 32'(GPR_NONE));
        check("mis csr",     32'(wb.csr_ctrl), 32'(CSR_NONE));
        check("mis exe_out", wb.exe_out, 32'h0000_3001);
        tick;
        check("mis pulse end", 32'(misaligned), 32'd0);
        check("mis no req 2",  32'(d_req), 32'd0);

        // 6: reset in RESP abandons the load; stray bus responses in IDLE are ignored
        exe_valid = 1'b1;
        exe_pl    = mk(MEM_LW, 32'h0000_4000, 32'h0, GPR_MEM, CSR_NONE);
        tick;
        exe_valid = 1'b0;
        d_gnt     = 1'b1;
        tick;
        d_gnt = 1'b0;
        rst   = 1'b1;
        #1;
        check("rst6 addr",  d_addr, 32'h0);
        check("rst6 be",    32'(d_be), 32'h0);
        check("rst6 req",   32'(d_req), 32'd0);
        check("rst6 ready", 32'(exe_ready), 32'd1);
        check("rst6 valid", 32'(wb_valid), 32'd0);
        tick;
        rst      = 1'b0;
        d_gnt    = 1'b1;
        d_rvalid = 1'b1;
        d_rdata  = 32'h1111_2222;
        tick;
        d_gnt    = 1'b0;
        d_rvalid = 1'b0;
        check("stray rvalid", 32'(wb_valid), 32'd0);
        check("stray gnt",    32'(d_req), 32'd0);
        do_load("lw after rst", MEM_LW, 32'h0000_4004, 32'h1234_5678, 32'h0000_4004, 4'b1111,
                32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
